apb_cmd_master: RTL

Single-outstanding APB master that sits directly upstream of the team's APB SRAM slave. It accepts read/write commands on a valid/ready request port and sequences them into APB SETUP/ACCESS phases. It waits for `pready`, with an optional timeout. Each completed transfer is returned on a valid/ready response port carrying read data and an error flag.

---
 rtl/apb_cmd_master.sv | 109 ++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: turns valid/ready commands into SETUP/ACCESS
// transfers and returns each result (read data, timeout flag) on a response port.
module apb_cmd_master #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 0
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int            TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam bit            TO_EN    = (TIMEOUT > 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          accept;

  // Accepting in RESP lets a consumed response overlap the next command's SETUP.
  assign req_ready = prst & ((state_reg == S_IDLE) | ((state_reg == S_RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state_reg)
        S_SETUP: begin
          state_reg <= S_ACCESS;
          penable   <= 1'b1;
          cnt_reg   <= '0;
        end
        S_ACCESS: begin
          if (pready) begin
            state_reg <= S_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
            state_reg <= S_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_reg <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase

      // A new command overrides the IDLE/RESP exit chosen above.
      if (accept) begin
        state_reg <= S_SETUP;
        psel      <= 1'b1;
        penable   <= 1'b0;
        paddr     <= req_addr;
        pwrite    <= req_write;
        if (req_write) begin
          pwdata <= req_wdata;
        end
      end
    end
  end

endmodule
